sprite_evaluator: RTL and testbench
===================================

Name: sprite_evaluator

Overview:
Per-scanline sprite evaluation stage, directly upstream of sprite_drawer. On request it scans every OAM entry and selects those whose 16-pixel-tall sprite covers the requested line. It builds the second_array that sprite_drawer consumes: OAM address plus active bit, in OAM order. It flags overflow when more sprites hit than second_array can hold.

Parameters:
OAM_ADDR_SIZE, 8, OAM address width; OAM holds 2**OAM_ADDR_SIZE entries.
OAM_DATA_SIZE, 32, OAM word width.
SECOND_ARRAY_SIZE, 32, number of second_array slots.
SPRITE_HEIGHT, 16, sprite height in lines (one VRAM word per row).
DISPLAY_WIDTH, 600, used only to size line_number.
LINE_NUMBER_WIDTH, $clog2(DISPLAY_WIDTH), line_number width (10).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  level request; rising while idle starts a scan; drop to release.
done  out  1  high while the result is valid and enable is still high.
line_number  in  LINE_NUMBER_WIDTH  target line; sampled on the start cycle.
oam_a  out  OAM_ADDR_SIZE  OAM read address.
oam_d  in  OAM_DATA_SIZE  OAM read data; valid one cycle after oam_a (synchronous RAM).
second_array  out  [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]  per slot: [OAM_ADDR_SIZE:1] OAM address, [0] active.
hit_count  out  $clog2(SECOND_ARRAY_SIZE)+1  number of active slots.
overflow  out  1  more than SECOND_ARRAY_SIZE sprites hit the line.

Behaviour:
- OAM word layout: [31:28] reserved; [27:18] y; [17:8] x; [7:0] tile. Only y is used here.
- Hit rule: diff = {1'b0,line} - {1'b0,y}, computed 11 bits wide. A hit requires the diff sign bit to be 0 and diff < SPRITE_HEIGHT, which gives y <= line < y+SPRITE_HEIGHT. There is no wrap.
- Software parks unused sprites at y >= 1000. These never hit.
- Reset: state IDLE, oam_a=0, done=0, overflow=0, hit_count=0, second_array all zero.
- FSM states: IDLE, SCAN, FLUSH, DONE.
  - IDLE: when enable=1, latch line_number, clear second_array, hit_count and overflow, set oam_a=0, go to SCAN.
  - SCAN: each cycle, evaluate oam_d for address oam_a-1 (no evaluation on the first SCAN cycle), then increment oam_a. After address 2**OAM_ADDR_SIZE-1 is presented, go to FLUSH.
  - FLUSH: evaluate the last entry, then go to DONE.
  - DONE: done=1. When enable=0, go to IDLE with done=0 the next cycle. second_array, hit_count and overflow stay held until the next start.
- Latency: done rises 2**OAM_ADDR_SIZE+2 cycles after the cycle enable is first sampled high (258 for defaults). This holds when there is no overflow.
- Hit with hit_count < SECOND_ARRAY_SIZE: write slot[hit_count] = {addr, 1'b1} and increment hit_count. Slots fill from index 0 in ascending OAM address order.
- Hit with hit_count == SECOND_ARRAY_SIZE: set overflow=1, stop the scan, and go to DONE next cycle. second_array is unchanged.
- Exactly SECOND_ARRAY_SIZE hits is not overflow.
- enable dropping mid-scan: the scan completes anyway, then DONE immediately returns to IDLE. done pulses for one cycle.
- rst mid-scan: return to the reset values the next cycle.
- line_number changes during a scan are ignored.
- second_array is driven only by registers (no combinational path from oam_d).

Decomposition:
- Package sprite_pkg:
  - oam_entry_t packed struct (reserved, y, x, tile).
  - second_entry_t (addr, active).
  - SPRITE_HEIGHT constant.
  - Shared with sprite_drawer.
- Sub-module sprite_line_hit: combinational compare of y and line against SPRITE_HEIGHT, producing hit. It is unit-testable on its own.

Test Plan:
- Basic hits: OAM entries 0..15 with y=0, the rest y=1000; line 0 → slots 0..15 = {i,1}, slots 16..31 = 0, hit_count=16, overflow=0, done at cycle 258.
- Row boundary: entry 3 y=100, others parked; line 99 → hit_count=0; line 100 → slot0={3,1}; line 115 → hit; line 116 → hit_count=0.
- Exact fill: entries 0..31 with y=50, others parked; line 60 → 32 active slots, overflow=0.
- Overflow: entries 0..40 with y=50; line 50 → slots hold 0..31, overflow=1, done asserted well before cycle 258.
- Order and sparse hits: entries 200, 7 and 255 hit → slot0=7, slot1=200, slot2=255; entry 255 evaluated in FLUSH.
- Control: assert rst at scan cycle 100 → all outputs reset next cycle. Hold enable high after done → outputs held. Drop enable → done=0 next cycle, second_array retained.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types for the sprite pipeline: OAM word layout, second_array slot
// layout and evaluator state encoding. Also consumed by sprite_drawer.
package sprite_pkg;

  localparam int unsigned SPRITE_HEIGHT = 16;

  typedef struct packed {
    logic [3:0] reserved;
    logic [9:0] y;
    logic [9:0] x;
    logic [7:0] tile;
  } oam_entry_t;

  typedef struct packed {
    logic [7:0] addr;
    logic       active;
  } second_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FLUSH,
    S_DONE
  } eval_state_t;

  function automatic logic [9:0] oam_y(input oam_entry_t e);
    return e.y;
  endfunction

endpackage

// File: rtl/sprite_evaluator_if.sv
// Request/result and OAM read bus of the sprite evaluator.
// The master side is the scan requester together with the OAM RAM.
interface sprite_evaluator_if #(
  parameter int unsigned OAM_ADDR_SIZE     = 8,
  parameter int unsigned OAM_DATA_SIZE     = 32,
  parameter int unsigned SECOND_ARRAY_SIZE = 32,
  parameter int unsigned LINE_NUMBER_WIDTH = 10,
  parameter int unsigned HIT_COUNT_WIDTH   = $clog2(SECOND_ARRAY_SIZE) + 1
);
  logic                                          enable;
  logic                                          done;
  logic [LINE_NUMBER_WIDTH-1:0]                  line_number;
  logic [OAM_ADDR_SIZE-1:0]                      oam_a;
  logic [OAM_DATA_SIZE-1:0]                      oam_d;
  logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0] second_array;
  logic [HIT_COUNT_WIDTH-1:0]                    hit_count;
  logic                                          overflow;

  modport master (
    output enable, line_number, oam_d,
    input  done, oam_a, second_array, hit_count, overflow
  );

  modport slave (
    input  enable, line_number, oam_d,
    output done, oam_a, second_array, hit_count, overflow
  );
endinterface

// File: rtl/sprite_line_hit.sv
// Combinational test of whether a sprite starting at row y covers line:
// y <= line < y + HEIGHT, with no wrap-around.
module sprite_line_hit #(
  parameter int unsigned Y_WIDTH = 10,
  parameter int unsigned HEIGHT  = 16
) (
  input  logic [Y_WIDTH-1:0] i_y,
  input  logic [Y_WIDTH-1:0] i_line,
  output logic               o_hit
);
  logic [Y_WIDTH:0] w_diff;

  // One extra bit holds the borrow, so lines above the sprite never hit.
  always_comb begin
    w_diff = {1'b0, i_line} - {1'b0, i_y};
    o_hit  = !w_diff[Y_WIDTH] && (w_diff[Y_WIDTH-1:0] < Y_WIDTH'(HEIGHT));
  end
endmodule

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluation: scans all OAM entries and collects the
// addresses of sprites covering the requested line into second_array.
module sprite_evaluator #(
  parameter int unsigned OAM_ADDR_SIZE     = 8,
  parameter int unsigned OAM_DATA_SIZE     = 32,
  parameter int unsigned SECOND_ARRAY_SIZE = 32,
  parameter int unsigned SPRITE_HEIGHT     = sprite_pkg::SPRITE_HEIGHT,
  parameter int unsigned DISPLAY_WIDTH     = 600,
  parameter int unsigned LINE_NUMBER_WIDTH = $clog2(DISPLAY_WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  sprite_evaluator_if.slave   bus
);
  import sprite_pkg::*;

  localparam int unsigned CNT_W = $clog2(SECOND_ARRAY_SIZE) + 1;
  localparam int unsigned IDX_W = $clog2(SECOND_ARRAY_SIZE);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SECOND_ARRAY_SIZE);

  eval_state_t                                   r_state;
  eval_state_t                                   w_next;
  logic [OAM_ADDR_SIZE-1:0]                      r_oam_a;
  logic [OAM_ADDR_SIZE-1:0]                      w_eval_addr;
  logic [LINE_NUMBER_WIDTH-1:0]                  r_line;
  logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0] r_array;
  logic [CNT_W-1:0]                              r_hit_count;
  logic                                          r_overflow;
  logic                                          r_first;
  logic [OAM_DATA_SIZE-1:0]                      w_oam_word;
  logic [LINE_NUMBER_WIDTH-1:0]                  w_y;
  logic                                          w_hit;
  logic                                          w_eval;
  logic                                          w_take;
  logic                                          w_full;
  second_entry_t                                 w_slot;

  assign w_oam_word = bus.oam_d;
  assign w_y        = LINE_NUMBER_WIDTH'(oam_y(oam_entry_t'(w_oam_word)));

  sprite_line_hit #(
    .Y_WIDTH (LINE_NUMBER_WIDTH),
    .HEIGHT  (SPRITE_HEIGHT)
  ) u_line_hit (
    .i_y    (w_y),
    .i_line (r_line),
    .o_hit  (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // oam_d always belongs to the address presented one cycle earlier, including
  // in FLUSH where r_oam_a has already wrapped past the last entry.
  always_comb begin
    w_next      = r_state;
    w_eval_addr = r_oam_a - OAM_ADDR_SIZE'(1);
    w_eval      = ((r_state == S_SCAN) && !r_first) || (r_state == S_FLUSH);
    w_take      = w_eval && w_hit;
    w_full      = (r_hit_count == FULL);
    w_slot      = '{addr: w_eval_addr, active: 1'b1};
    case (r_state)
      S_IDLE:  if (bus.enable) w_next = S_SCAN;
      S_SCAN: begin
        if (w_take && w_full)   w_next = S_DONE;
        else if (r_oam_a == '1) w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_DONE;
      S_DONE:  if (!bus.enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oam_a     <= '0;
      r_line      <= '0;
      r_array     <= '0;
      r_hit_count <= '0;
      r_overflow  <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_line      <= bus.line_number;
            r_array     <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
            r_oam_a     <= '0;
            r_first     <= 1'b1;
          end
        end
        S_SCAN: begin
          r_first <= 1'b0;
          r_oam_a <= r_oam_a + OAM_ADDR_SIZE'(1);
        end
        default: ;
      endcase
      if (w_take) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_array[r_hit_count[IDX_W-1:0]] <= w_slot;
          r_hit_count                     <= r_hit_count + CNT_W'(1);
        end
      end
    end
  end

  assign bus.oam_a        = r_oam_a;
  assign bus.done         = (r_state == S_DONE);
  assign bus.second_array = r_array;
  assign bus.hit_count    = r_hit_count;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_sprite_evaluator.sv
// Directed bench for sprite_evaluator: a reference model fills a scoreboard
// when each scan is requested and the entry is checked when done appears.
module tb_sprite_evaluator;
  localparam int SA = 32;
  localparam int AW = 8;
  localparam int CW = 6;

  typedef logic [SA*(AW+1)-1:0] arr_t;
  typedef struct {
    arr_t            arr;
    logic [CW-1:0]   cnt;
    logic            ovf;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_evaluator_if #(
    .OAM_ADDR_SIZE     (8),
    .OAM_DATA_SIZE     (32),
    .SECOND_ARRAY_SIZE (32),
    .LINE_NUMBER_WIDTH (10)
  ) bus ();

  sprite_evaluator #(
    .OAM_ADDR_SIZE     (8),
    .OAM_DATA_SIZE     (32),
    .SECOND_ARRAY_SIZE (32),
    .SPRITE_HEIGHT     (16),
    .DISPLAY_WIDTH     (600)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] oam [256];
  always @(posedge clk) bus.oam_d <= oam[bus.oam_a];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arr(input string tag, input arr_t obs, input arr_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic park_all();
    for (int i = 0; i < 256; i++) oam[i] = {4'h0, 10'd1000, 10'(i), 8'(i)};
  endtask

  task automatic set_y(input int a, input int y);
    oam[a][27:18] = 10'(y);
  endtask

  function automatic exp_t model(input int line);
    exp_t e;
    int   n;
    int   y;
    e.arr = '0;
    e.ovf = 1'b0;
    e.lat = 258;
    n     = 0;
    for (int a = 0; a < 256; a++) begin
      y = int'(oam[a][27:18]);
      if (line >= y && line < y + 16) begin
        if (n == SA) begin
          e.ovf = 1'b1;
          e.lat = a + 3;
          break;
        end
        e.arr[n*(AW+1) +: (AW+1)] = {8'(a), 1'b1};
        n++;
      end
    end
    e.cnt = CW'(n);
    return e;
  endfunction

  task automatic run_scan(input string tag, input int line, input int drop_at, input int change_at);
    exp_t e;
    int   cyc;
    logic seen;
    sb.push_back(model(line));
    @(posedge clk); #1;
    bus.line_number = 10'(line);
    bus.enable      = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 400 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == drop_at)   bus.enable = 1'b0;
      if (cyc == change_at) bus.line_number = 10'(line + 300);
      seen = bus.done;
    end
    e = sb.pop_front();
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".latency"}, 64'(cyc), 64'(e.lat));
    chk_arr({tag, ".second_array"}, bus.second_array, e.arr);
    chk({tag, ".hit_count"}, 64'(bus.hit_count), 64'(e.cnt));
    chk({tag, ".overflow"}, 64'(bus.overflow), 64'(e.ovf));
    if (drop_at > 0) begin
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    end else begin
      @(posedge clk); #1;
      chk({tag, ".done_held"}, 64'(bus.done), 64'd1);
      chk_arr({tag, ".array_held"}, bus.second_array, e.arr);
      bus.enable = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".done_release"}, 64'(bus.done), 64'd0);
    end
    chk_arr({tag, ".array_kept"}, bus.second_array, e.arr);
    chk({tag, ".count_kept"}, 64'(bus.hit_count), 64'(e.cnt));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".done"}, 64'(bus.done), 64'd0);
    chk({tag, ".oam_a"}, 64'(bus.oam_a), 64'd0);
    chk({tag, ".hit_count"}, 64'(bus.hit_count), 64'd0);
    chk({tag, ".overflow"}, 64'(bus.overflow), 64'd0);
    chk_arr({tag, ".second_array"}, bus.second_array, '0);
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.line_number = '0;
    park_all();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) set_y(i, 0);
    run_scan("basic", 0, -1, -1);
    run_scan("line_change", 0, -1, 50);

    park_all();
    set_y(3, 100);
    run_scan("row99", 99, -1, -1);
    run_scan("row100", 100, -1, -1);
    run_scan("row115", 115, -1, -1);
    run_scan("row116", 116, -1, -1);

    park_all();
    for (int i = 0; i < 32; i++) set_y(i, 50);
    run_scan("exact_fill", 60, -1, -1);

    park_all();
    for (int i = 0; i <= 40; i++) set_y(i, 50);
    run_scan("overflow", 50, -1, -1);

    park_all();
    set_y(200, 300);
    set_y(7, 300);
    set_y(255, 300);
    run_scan("sparse", 305, -1, -1);
    run_scan("drop_mid", 305, 10, -1);

    park_all();
    for (int i = 0; i < 4; i++) set_y(i, 0);
    @(posedge clk); #1;
    bus.line_number = '0;
    bus.enable      = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("mid_rst");
    rst        = 1'b0;
    bus.enable = 1'b0;
    @(posedge clk);

    run_scan("after_rst", 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
